// File: rtl/gaussian_blur3.sv
// gaussian_blur3: 3x3 binomial (1 2 1 / 2 4 2 / 1 2 1) blur of a square
// 8-bit greyscale image read from a source BRAM and written in raster order
// to a destination BRAM. Border taps are clamped (edge replicate).
//
// state | meaning
// IDLE  | waiting for start, busy low
// FETCH | issue the 9 clamped tap addresses, one per cycle
// DRAIN | wait READ_LATENCY cycles for the last tap data to be accumulated
// WRITE | one destination write of the rounded result
// DONE  | one-cycle done pulse, then back to IDLE
module gaussian_blur3 #(
  parameter int DIMENSION    = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_in,
  input  logic                                   start,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] src_addr,
  input  logic [7:0]                             src_pix,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] dst_addr,
  output logic [7:0]                             dst_data,
  output logic                                   dst_we,
  output logic                                   busy,
  output logic                                   done
);

  localparam int AW = $clog2(DIMENSION*DIMENSION);
  localparam int CW = $clog2(DIMENSION);
  localparam int DW = $clog2(READ_LATENCY+1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   row, col, nrow, ncol;
  logic [3:0]      tap;
  logic [DW-1:0]   dcnt;
  logic [11:0]     acc, acc_nxt, sum_rnd;
  logic            last_pix;
  logic            vpipe [1:READ_LATENCY];
  logic [2:0]      wpipe [1:READ_LATENCY];

  // Clamped source address of tap k around pixel (r, c).
  function automatic logic [AW-1:0] tap_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c,
                                             input logic [3:0]    k);
    int rr, cc;
    rr = int'(r) + (int'(k) / 3) - 1;
    cc = int'(c) + (int'(k) % 3) - 1;
    if (rr < 0) rr = 0;
    else if (rr > DIMENSION-1) rr = DIMENSION-1;
    if (cc < 0) cc = 0;
    else if (cc > DIMENSION-1) cc = DIMENSION-1;
    return AW'(rr * DIMENSION + cc);
  endfunction

  function automatic logic [2:0] tap_weight(input logic [3:0] k);
    case (k)
      4'd4:                      return 3'd4;
      4'd1, 4'd3, 4'd5, 4'd7:    return 3'd2;
      default:                   return 3'd1;
    endcase
  endfunction

  // Next-pixel coordinates and accumulator update from the delayed tap pipeline.
  always_comb begin
    last_pix = (row == CW'(DIMENSION-1)) && (col == CW'(DIMENSION-1));
    ncol     = col + CW'(1);
    nrow     = (col == CW'(DIMENSION-1)) ? row + CW'(1) : row;
    acc_nxt  = acc;
    if (vpipe[READ_LATENCY])
      acc_nxt = acc + ({4'b0, src_pix} * {9'b0, wpipe[READ_LATENCY]});
    sum_rnd  = acc_nxt + 12'd8;
  end

  // Tap-valid / weight delay line aligning each weight with its returning pixel.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 1; i <= READ_LATENCY; i++) begin
        vpipe[i] <= 1'b0;
        wpipe[i] <= 3'd0;
      end
    end else begin
      vpipe[1] <= (state == FETCH);
      wpipe[1] <= tap_weight(tap);
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        wpipe[i] <= wpipe[i-1];
      end
    end
  end

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      tap      <= '0;
      dcnt     <= '0;
      acc      <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      dst_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      dst_we <= 1'b0;
      done   <= 1'b0;
      acc    <= acc_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            row      <= '0;
            col      <= '0;
            tap      <= '0;
            acc      <= '0;
            busy     <= 1'b1;
            src_addr <= tap_addr('0, '0, 4'd0);
          end
        end
        FETCH: begin
          if (tap == 4'd8) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            tap      <= tap + 4'd1;
            src_addr <= tap_addr(row, col, tap + 4'd1);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(READ_LATENCY-1)) begin
            state    <= WRITE;
            dst_we   <= 1'b1;
            dst_addr <= {row, col};
            dst_data <= sum_rnd[11:4];
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        WRITE: begin
          acc <= '0;
          if (last_pix) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= FETCH;
            tap      <= '0;
            col      <= ncol;
            row      <= nrow;
            src_addr <= tap_addr(nrow, ncol, 4'd0);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_blur3.sv
// tb_gaussian_blur3: directed bench for gaussian_blur3 (8x8 image, 2-cycle BRAM).
module tb_gaussian_blur3;
  localparam int D  = 8;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       start = 1'b0;
  logic [5:0] src_addr, dst_addr;
  logic [7:0] src_pix, dst_data;
  logic       dst_we, busy, done;

  logic [7:0] mem [0:63];
  logic [7:0] rd1;
  logic [7:0] out_img [0:63];

  int checks = 0, failures = 0;
  int cyc = 0, cyc_start = 0;
  int wr_cnt, order_err, first_we, last_we, done_cnt, done_cyc;
  int busy_first, busy_last, busy_seen;
  logic busy_at_done;

  gaussian_blur3 #(.DIMENSION(D), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .src_addr(src_addr), .src_pix(src_pix),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-cycle registered source BRAM.
  always @(posedge clk) begin
    rd1     <= mem[src_addr];
    src_pix <= rd1;
    cyc     <= cyc + 1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int rel;
    rel = cyc - cyc_start;
    if (!rst_in) begin
      if (dst_we) begin
        if (int'(dst_addr) != wr_cnt) order_err++;
        out_img[dst_addr] = dst_data;
        if (wr_cnt == 0) first_we = rel;
        last_we = rel;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
        busy_at_done = busy;
      end
      if (busy) begin
        if (busy_seen == 0) busy_first = rel;
        busy_seen = 1;
        busy_last = rel;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  // Called at a negedge: that cycle is cycle 0, start sampled at its end.
  task automatic start_pass();
    wr_cnt = 0; order_err = 0; first_we = -1; last_we = -1;
    done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1; busy_seen = 0;
    busy_at_done = 1'bx;
    for (int i = 0; i < 64; i++) out_img[i] = 8'hEE;
    cyc_start = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", (done_cnt > 0), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] v);
    for (int i = 0; i < 64; i++) chk(tag, out_img[i], v);
  endtask

  initial begin
    fill(8'd0);
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_dst_addr", dst_addr, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_dst_we", dst_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Constant image, plus an ignored start mid-pass at cycle 100.
    fill(8'd100);
    start_pass();
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk_all("const100_pix", 8'd100);
    chk("const100_writes", wr_cnt, 64);
    chk("const100_order", order_err, 0);
    chk("const100_first_we", first_we, 12);
    chk("const100_last_we", last_we, 768);
    chk("const100_done_cnt", done_cnt, 1);
    chk("const100_done_cyc", done_cyc, 769);
    chk("const100_busy_at_done", busy_at_done, 0);

    // Centre impulse.
    fill(8'd0);
    mem[3*8+3] = 8'd255;
    start_pass();
    wait_done();
    chk("imp_33", out_img[3*8+3], 64);
    chk("imp_34", out_img[3*8+4], 32);
    chk("imp_43", out_img[4*8+3], 32);
    chk("imp_44", out_img[4*8+4], 16);
    chk("imp_55", out_img[5*8+5], 0);
    chk("imp_22", out_img[2*8+2], 16);
    chk("imp_writes", wr_cnt, 64);

    // Corner impulse exercises clamping.
    fill(8'd0);
    mem[0] = 8'd160;
    start_pass();
    wait_done();
    chk("corner_00", out_img[0], 90);
    chk("corner_01", out_img[1], 30);
    chk("corner_10", out_img[8], 30);
    chk("corner_11", out_img[9], 10);
    chk("corner_77", out_img[63], 0);
    chk("corner_writes", wr_cnt, 64);
    chk("corner_order", order_err, 0);

    // Saturated image.
    fill(8'd255);
    start_pass();
    wait_done();
    chk_all("full255_pix", 8'd255);
    chk("full255_busy_first", busy_first, 1);
    chk("full255_busy_last", busy_last, 768);
    chk("full255_done_cyc", done_cyc, 769);

    // Reset during pixel 5 FETCH (cycles 61-69), then a fresh pass.
    fill(8'd77);
    start_pass();
    repeat (62) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_we", dst_we, 0);
    rst_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_writes", wr_cnt, 5);
    chk("midrst_no_done", done_cnt, 0);
    start_pass();
    wait_done();
    chk_all("rerun_pix", 8'd77);
    chk("rerun_writes", wr_cnt, 64);
    chk("rerun_order", order_err, 0);
    chk("rerun_done_cyc", done_cyc, 769);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gaussian_blur3.md
Name: gaussian_blur3

Overview:
- Produces the "fuzzier" image consumed by dog by applying a 3x3 binomial Gaussian to an 8-bit greyscale image held in a source BRAM.
- Writes the blurred image, in raster order, into a destination BRAM.
- Sits directly upstream of dog: the source BRAM is the UART-loaded image; the destination BRAM feeds dog's fuzzier_pix port.
- Removes the need to upload a second, pre-blurred image from the laptop.

Parameters:
- DIMENSION, 64: image width and height in pixels; square image, power of two.
- READ_LATENCY, 2: source BRAM read latency in cycles, from address to data.

Ports:
- clk  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- start  input  1  single-cycle pulse; begins a blur pass when idle.
- src_addr  output  $clog2(DIMENSION*DIMENSION)  source BRAM read address, row*DIMENSION+col.
- src_pix  input  8  source BRAM read data; valid READ_LATENCY cycles after src_addr.
- dst_addr  output  $clog2(DIMENSION*DIMENSION)  destination BRAM write address.
- dst_data  output  8  blurred pixel.
- dst_we  output  1  destination write enable; one cycle per pixel.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset values: src_addr=0, dst_addr=0, dst_data=0, dst_we=0, busy=0, done=0; FSM in IDLE; row/col counters and accumulator cleared.
- Reset mid-pass: FSM returns to IDLE immediately, no further writes are issued, and the next start restarts at pixel 0.
- Kernel weights, row-major over taps k=0..8 at offsets (dy,dx) from (-1,-1) to (+1,+1): 1 2 1 / 2 4 2 / 1 2 1.
- Output: out = (sum + 8) >> 4. The 12-bit accumulator cannot overflow (max 4080+8), so no saturation is needed.
- Borders: tap coordinates are clamped to [0, DIMENSION-1] on each axis (edge replicate). No wrap-around is allowed.
- States:
  - IDLE: busy=0; start moves to FETCH with row=col=0 and the accumulator cleared.
  - FETCH: 9 cycles; issue the clamped src_addr for tap k=0..8, one per cycle.
  - DRAIN: READ_LATENCY cycles.
  - WRITE: 1 cycle; dst_we=1, dst_addr=row*DIMENSION+col, dst_data=rounded result; accumulator cleared.
    - Then: if this was the last pixel, go to DONE; otherwise advance col (wrapping to 0 and incrementing row at col=DIMENSION-1) and go to FETCH.
  - DONE: 1 cycle; done=1, busy=0; then IDLE.
- Accumulation: src_pix is multiplied by weight[k] and added to the accumulator exactly READ_LATENCY cycles after tap k's address was issued, using a delayed tap-valid/weight pipeline.
  - The accumulator is complete in the cycle before WRITE.
- Timing, with start sampled at cycle 0:
  - busy=1 from cycle 1; FETCH spans cycles 1-9.
  - Per-pixel period P = 10+READ_LATENCY (12 by default); first dst_we at cycle P.
  - Last dst_we at cycle P*DIMENSION^2; done pulses at cycle P*DIMENSION^2+1, with busy=0 in that cycle.
- start while busy or in DONE is ignored. start coincident with rst_in is ignored.
- dst_we is never asserted outside WRITE. src_addr holds its last value outside FETCH.

Test Plan (DIMENSION=8, READ_LATENCY=2, behavioural 2-cycle BRAM model):
- Constant image of 100, pulse start -> all 64 written pixels = 100; exactly 64 dst_we pulses at addresses 0..63 in order; done at cycle 769.
- Zero image with 255 at (3,3) -> out(3,3)=64, out(3,4)=32, out(4,3)=32, out(4,4)=16, out(5,5)=0, out(2,2)=16.
- Zero image with 160 at (0,0) (clamp check) -> out(0,0)=90, out(0,1)=(160*3+8)>>4=30, out(1,1)=10; no write to an address outside 0..63.
- All-255 image -> every output = 255 (no overflow); busy high from cycle 1 through cycle 768.
- Assert rst_in during the pixel-5 FETCH -> busy=0 and dst_we=0 next cycle, no done; re-pulse start -> a full correct pass from address 0.
- Pulse start again at cycle 100 mid-pass -> ignored: still exactly 64 writes and a single done at cycle 769.
